// File: rtl/pacman_pkg.sv
// Shared encodings and screen constants for the Pacman motion controller.
`timescale 1ns/1ps
package pacman_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int SPRITE_SIZE = 16;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_MOVE,
        ST_COMMIT
    } state_t;

    // Lowest set bit wins, so right beats left beats up beats down.
    function automatic dir_t lowest_set(input logic [3:0] v);
        dir_t d;
        d = DIR_RIGHT;
        if (v[0])      d = DIR_RIGHT;
        else if (v[1]) d = DIR_LEFT;
        else if (v[2]) d = DIR_UP;
        else if (v[3]) d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/pacman_motion_ctrl_if.sv
// Game-facing signal bundle: frame/cursor inputs and committed sprite state.
`timescale 1ns/1ps
interface pacman_motion_ctrl_if;
    import pacman_pkg::*;

    logic       frame_tick;
    logic       enable;
    logic [3:0] cursor;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    dir_t       direction;
    logic [1:0] frame_select;
    logic       moving;
    logic       update_done;

    modport master (
        output frame_tick, enable, cursor,
        input  pac_x, pac_y, direction, frame_select, moving, update_done
    );

    modport slave (
        input  frame_tick, enable, cursor,
        output pac_x, pac_y, direction, frame_select, moving, update_done
    );

endinterface

// File: rtl/pacman_anim_ctr.sv
// Animation prescaler: advances the 2-bit sprite frame every ANIM_DIV moving frames.
`timescale 1ns/1ps
module pacman_anim_ctr #(
    parameter int ANIM_DIV = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [1:0] frame_select
);

    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [CW-1:0] anim_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            anim_cnt     <= '0;
            frame_select <= 2'd0;
        end else if (inc) begin
            if (anim_cnt == CW'(ANIM_DIV - 1)) begin
                anim_cnt     <= '0;
                frame_select <= frame_select + 2'd1;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pacman position/heading update: latch presses, then CAPTURE/MOVE/COMMIT
// once per accepted frame_tick so outputs stay stable through the visible frame.
`timescale 1ns/1ps
module pacman_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int SCALE    = 4,
    parameter int STEP     = 2,
    parameter int ANIM_DIV = 20,
    parameter int X0       = 288,
    parameter int Y0       = 208
) (
    input  logic                 clk,
    input  logic                 rst,
    pacman_motion_ctrl_if.slave  bus
);

    localparam int          FOOT   = SPRITE_SIZE * SCALE;
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - FOOT);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - FOOT);
    localparam logic [10:0] STEP_W = 11'(STEP);

    state_t      state, state_n;
    logic [3:0]  pending;
    logic [3:0]  captured;
    dir_t        req_dir;
    logic        moving_n;
    logic [9:0]  nx, ny;
    logic [10:0] x_ext, y_ext;
    logic [9:0]  move_x, move_y;
    logic        move_go;

    logic [9:0]  pac_x_r, pac_y_r;
    dir_t        direction_r;
    logic        moving_r;
    logic        update_done_r;
    logic        anim_inc;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (bus.frame_tick && bus.enable) state_n = ST_CAPTURE;
            ST_CAPTURE: state_n = ST_MOVE;
            ST_MOVE:    state_n = ST_COMMIT;
            ST_COMMIT:  state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Include this cycle's cursor so a press landing on the capture cycle is kept.
    assign captured = pending | bus.cursor;

    always_comb begin
        x_ext   = {1'b0, pac_x_r};
        y_ext   = {1'b0, pac_y_r};
        move_x  = pac_x_r;
        move_y  = pac_y_r;
        move_go = moving_n;
        if (moving_n) begin
            case (req_dir)
                DIR_RIGHT: move_x = (x_ext + STEP_W > X_MAX) ? 10'd0 : 10'(x_ext + STEP_W);
                DIR_LEFT:  move_x = (x_ext < STEP_W) ? X_MAX[9:0] : 10'(x_ext - STEP_W);
                DIR_UP: begin
                    if (y_ext < STEP_W) begin
                        move_y  = 10'd0;
                        move_go = 1'b0;
                    end else begin
                        move_y = 10'(y_ext - STEP_W);
                    end
                end
                DIR_DOWN: begin
                    if (y_ext + STEP_W >= Y_MAX) begin
                        move_y  = Y_MAX[9:0];
                        move_go = 1'b0;
                    end else begin
                        move_y = 10'(y_ext + STEP_W);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= 4'd0;
            req_dir       <= DIR_RIGHT;
            moving_n      <= 1'b0;
            nx            <= 10'(X0);
            ny            <= 10'(Y0);
            pac_x_r       <= 10'(X0);
            pac_y_r       <= 10'(Y0);
            direction_r   <= DIR_RIGHT;
            moving_r      <= 1'b0;
            update_done_r <= 1'b0;
        end else begin
            pending       <= (state == ST_CAPTURE) ? 4'd0 : captured;
            update_done_r <= 1'b0;
            case (state)
                ST_CAPTURE: begin
                    if (captured != 4'd0) begin
                        req_dir  <= lowest_set(captured);
                        moving_n <= 1'b1;
                    end else begin
                        req_dir  <= direction_r;
                        moving_n <= moving_r;
                    end
                end
                ST_MOVE: begin
                    nx       <= move_x;
                    ny       <= move_y;
                    moving_n <= move_go;
                end
                ST_COMMIT: begin
                    pac_x_r       <= nx;
                    pac_y_r       <= ny;
                    direction_r   <= req_dir;
                    moving_r      <= moving_n;
                    update_done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign anim_inc = (state == ST_COMMIT) && moving_n;

    pacman_anim_ctr #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk          (clk),
        .rst          (rst),
        .inc          (anim_inc),
        .frame_select (bus.frame_select)
    );

    assign bus.pac_x       = pac_x_r;
    assign bus.pac_y       = pac_y_r;
    assign bus.direction   = direction_r;
    assign bus.moving      = moving_r;
    assign bus.update_done = update_done_r;

endmodule
